// File: rtl/ticket_pkg.sv
// ============================================================
// ticket_pkg: shared encodings for the seat booking controller
// Revision: 1.0
// ============================================================
`default_nettype none

package ticket_pkg;

  localparam int DEFAULT_CAPACITY = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_REJECT = 2'd3
  } state_e;

  typedef enum logic {
    OP_BOOK   = 1'b0,
    OP_CANCEL = 1'b1
  } op_e;

  // A request is legal when it asks for at least one seat and no more than the limit.
  function automatic logic qty_legal(input logic [2:0] q, input logic [7:0] limit);
    return (q != 3'd0) && ({5'd0, q} <= limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================
// btn_debounce: two-flop synchronizer, level debouncer and rising-edge pulse
// Revision: 1.0
// ============================================================
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;
  logic          w_differs;

  assign w_differs = r_sync[1] ^ r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_q <= r_level;
      // Level flips on the DB_CYCLES-th consecutive clock that disagrees with it.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_level & ~r_level_q;

endmodule

`default_nettype wire

// File: rtl/booking_controller.sv
// ============================================================
// booking_controller: debounced book/cancel seat counter with check/commit FSM
// Revision: 1.0
// ============================================================
`default_nettype none

module booking_controller
  import ticket_pkg::*;
#(
  parameter int CAPACITY  = DEFAULT_CAPACITY,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_book,
  input  logic       btn_cancel,
  input  logic [2:0] qty,
  output logic [7:0] avail,
  output logic [7:0] sold,
  output logic       sold_out,
  output logic       done,
  output logic       err,
  output logic       busy
);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Reset asserts asynchronously but releases two clocks later, so the first edge is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic w_book_lvl, w_book_pulse, w_cancel_lvl, w_cancel_pulse;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_book (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_btn   (btn_book),
    .o_level (w_book_lvl),
    .o_pulse (w_book_pulse)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_cancel (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_btn   (btn_cancel),
    .o_level (w_cancel_lvl),
    .o_pulse (w_cancel_pulse)
  );

  state_e     r_state, w_state_next;
  op_e        r_op, w_op_next;
  logic [2:0] r_qty, w_qty_next;
  logic [7:0] r_avail, w_avail_next;
  logic [7:0] r_sold, w_sold_next;
  logic       r_sold_out, w_sold_out_next;
  logic       r_done, w_done_next;
  logic       r_err, w_err_next;

  logic [8:0] w_qty9, w_avail9, w_sold9;
  logic       w_ovf;
  logic       w_legal;
  logic [7:0] w_limit;

  assign w_qty9   = {6'd0, r_qty};
  assign w_avail9 = (r_op == OP_BOOK) ? ({1'b0, r_avail} - w_qty9) : ({1'b0, r_avail} + w_qty9);
  assign w_sold9  = (r_op == OP_BOOK) ? ({1'b0, r_sold} + w_qty9)  : ({1'b0, r_sold} - w_qty9);
  // Cannot occur after a legal check; guards the counters if it ever did.
  assign w_ovf    = w_avail9[8] | w_sold9[8];
  assign w_limit  = (r_op == OP_BOOK) ? r_avail : r_sold;
  assign w_legal  = qty_legal(qty, w_limit);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_BOOK;
      r_qty      <= 3'd0;
      r_avail    <= 8'(CAPACITY);
      r_sold     <= 8'd0;
      r_sold_out <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_op       <= w_op_next;
      r_qty      <= w_qty_next;
      r_avail    <= w_avail_next;
      r_sold     <= w_sold_next;
      r_sold_out <= w_sold_out_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_op_next       = r_op;
    w_qty_next      = r_qty;
    w_avail_next    = r_avail;
    w_sold_next     = r_sold;
    w_sold_out_next = r_sold_out;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Book has priority; a simultaneous cancel is dropped.
        if (w_book_pulse) begin
          w_op_next    = OP_BOOK;
          w_state_next = ST_CHECK;
        end else if (w_cancel_pulse) begin
          w_op_next    = OP_CANCEL;
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_qty_next   = qty;
        w_state_next = w_legal ? ST_COMMIT : ST_REJECT;
      end
      ST_COMMIT: begin
        if (!w_ovf) begin
          w_avail_next    = w_avail9[7:0];
          w_sold_next     = w_sold9[7:0];
          w_sold_out_next = (w_avail9 == 9'd0);
        end
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_REJECT: begin
        w_err_next   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign avail    = r_avail;
  assign sold     = r_sold;
  assign sold_out = r_sold_out;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_booking_controller.sv
// ============================================================
// tb_booking_controller: directed self-checking bench, CAPACITY=10, DB_CYCLES=4
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_booking_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_book = 1'b0;
  logic       btn_cancel = 1'b0;
  logic [2:0] qty = 3'd0;
  logic [7:0] avail, sold;
  logic       sold_out, done, err, busy;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  logic bad_both = 1'b0;
  logic bad_inv  = 1'b0;

  booking_controller #(.CAPACITY(10), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_book   (btn_book),
    .btn_cancel (btn_cancel),
    .qty        (qty),
    .avail      (avail),
    .sold       (sold),
    .sold_out   (sold_out),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and tallying pulses.
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (done === 1'b1 && err === 1'b1) bad_both = 1'b1;
      if ((32'(avail) + 32'(sold)) !== 32'd10) bad_inv = 1'b1;
    end
  endtask

  task automatic press(input logic book, input logic cancel, input logic bounce);
    n_done = 0;
    n_err  = 0;
    if (bounce) begin
      repeat (3) begin
        btn_book = book; btn_cancel = cancel; cycles(1);
        btn_book = 1'b0; btn_cancel = 1'b0;   cycles(1);
      end
    end
    btn_book = book; btn_cancel = cancel;
    cycles(20);
    btn_book = 1'b0; btn_cancel = 1'b0;
    cycles(15);
  endtask

  task automatic do_reset();
    btn_book = 1'b0; btn_cancel = 1'b0;
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
  endtask

  initial begin
    int k;
    do_reset();
    check("reset_avail", avail, 10);
    check("reset_sold", sold, 0);
    check("reset_sold_out", sold_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);

    qty = 3'd3; press(1'b1, 1'b0, 1'b1);
    check("bounce_book_done_cnt", n_done, 1);
    check("bounce_book_err_cnt", n_err, 0);
    check("bounce_book_avail", avail, 7);
    check("bounce_book_sold", sold, 3);
    check("bounce_book_sold_out", sold_out, 0);

    qty = 3'd7; press(1'b1, 1'b0, 1'b0);
    check("book7_done_cnt", n_done, 1);
    check("book7_avail", avail, 0);
    check("book7_sold", sold, 10);
    check("book7_sold_out", sold_out, 1);

    qty = 3'd1; press(1'b1, 1'b0, 1'b0);
    check("full_book_err_cnt", n_err, 1);
    check("full_book_done_cnt", n_done, 0);
    check("full_book_avail", avail, 0);
    check("full_book_sold", sold, 10);

    do_reset();
    qty = 3'd3; press(1'b1, 1'b0, 1'b0);
    check("rebook_avail", avail, 7);
    qty = 3'd5; press(1'b0, 1'b1, 1'b0);
    check("cancel5_err_cnt", n_err, 1);
    check("cancel5_done_cnt", n_done, 0);
    check("cancel5_sold", sold, 3);
    qty = 3'd0; press(1'b0, 1'b1, 1'b0);
    check("cancel0_err_cnt", n_err, 1);
    check("cancel0_sold", sold, 3);
    qty = 3'd2; press(1'b0, 1'b1, 1'b0);
    check("cancel2_done_cnt", n_done, 1);
    check("cancel2_avail", avail, 9);
    check("cancel2_sold", sold, 1);
    check("cancel2_sold_out", sold_out, 0);

    do_reset();
    qty = 3'd2; press(1'b1, 1'b1, 1'b0);
    check("both_done_cnt", n_done, 1);
    check("both_err_cnt", n_err, 0);
    check("both_avail", avail, 8);
    check("both_sold", sold, 2);

    // Button held across reset release still books once debounced.
    qty = 3'd1; n_done = 0; n_err = 0;
    rst_n = 1'b0; btn_book = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    btn_book = 1'b0;
    cycles(15);
    check("held_rst_done_cnt", n_done, 1);
    check("held_rst_avail", avail, 9);
    check("held_rst_sold", sold, 1);

    qty = 3'd1; btn_book = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 30) begin
      cycles(1);
      k++;
    end
    check("busy_reached", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreq_avail", avail, 10);
    check("midreq_sold", sold, 0);
    check("midreq_busy", busy, 0);
    check("midreq_done", done, 0);
    check("midreq_err", err, 0);
    check("midreq_sold_out", sold_out, 0);
    btn_book = 1'b0;
    n_done = 0; n_err = 0;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    check("post_abort_done_cnt", n_done, 0);
    check("post_abort_err_cnt", n_err, 0);
    check("post_abort_avail", avail, 10);

    check("done_err_exclusive", bad_both, 0);
    check("avail_plus_sold", bad_inv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
